// File: rtl/angle_float_to_fixed.sv
// angle_float_to_fixed: three-stage IEEE-754 single to signed Q2.30 angle
// converter, clamped to [-1.0, +1.0], feeding the CORDIC cosine core.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset, overrides clk_en
//   clk_en    pipeline advance enable shared with the cosine core
//   in_valid  angle carries a sample (sampled only when clk_en=1)
//   angle     IEEE-754 single-precision input
//   out_valid fixed/flags carry a result
//   fixed     signed Q2.30 result (0x40000000 = +1.0)
//   flags     [0] saturated (|x| > 1.0 or Inf), [1] NaN input
module angle_float_to_fixed (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        in_valid,
    input  logic [31:0] angle,
    output logic        out_valid,
    output logic [31:0] fixed,
    output logic [1:0]  flags
);

    localparam logic [31:0] POS_ONE = 32'h4000_0000;
    localparam logic [31:0] NEG_ONE = 32'hC000_0000;

    // Stage 1: unpack and classify
    logic        v1;
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [23:0] s1_mag;
    logic        s1_zero;
    logic        s1_nan;
    logic        s1_sat;

    // Stage 2: aligned magnitude
    logic        v2;
    logic        s2_sign;
    logic [31:0] s2_mag;
    logic        s2_nan;
    logic        s2_sat;

    logic [7:0]  in_exp;
    logic [22:0] in_man;
    logic        in_nan;
    logic        in_inf;
    logic        in_ovf;
    logic [31:0] aligned;
    logic [31:0] negated;

    assign in_exp = angle[30:23];
    assign in_man = angle[22:0];
    assign in_nan = (in_exp == 8'd255) && (in_man != 23'd0);
    assign in_inf = (in_exp == 8'd255) && (in_man == 23'd0);
    // e=255 is handled by the NaN/Inf terms; everything above 1.0 saturates
    assign in_ovf = (in_exp > 8'd127)
                 || ((in_exp == 8'd127) && (in_man != 23'd0));

    // Q2.30 places 1.0 at bit 30 and the hidden bit sits at bit 23, so an
    // exponent of 120 needs no shift. Below 97 every bit falls off the end.
    always_comb begin
        aligned = 32'd0;
        if (s1_zero) begin
            aligned = 32'd0;
        end else if (s1_exp >= 8'd120) begin
            aligned = {8'd0, s1_mag} << (s1_exp - 8'd120);
        end else if (s1_exp >= 8'd97) begin
            aligned = {8'd0, s1_mag} >> (8'd120 - s1_exp);
        end
    end

    assign negated = 32'd0 - s2_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            s1_sign   <= 1'b0;
            s1_exp    <= 8'd0;
            s1_mag    <= 24'd0;
            s1_zero   <= 1'b1;
            s1_nan    <= 1'b0;
            s1_sat    <= 1'b0;
            v2        <= 1'b0;
            s2_sign   <= 1'b0;
            s2_mag    <= 32'd0;
            s2_nan    <= 1'b0;
            s2_sat    <= 1'b0;
            out_valid <= 1'b0;
            fixed     <= 32'd0;
            flags     <= 2'b00;
        end else if (clk_en) begin
            v1      <= in_valid;
            s1_sign <= angle[31];
            s1_exp  <= in_exp;
            s1_mag  <= {in_exp != 8'd0, in_man};
            s1_zero <= (in_exp == 8'd0);
            s1_nan  <= in_nan;
            s1_sat  <= in_inf || (in_ovf && !in_nan);

            v2      <= v1;
            s2_sign <= s1_sign;
            s2_mag  <= aligned;
            s2_nan  <= s1_nan;
            s2_sat  <= s1_sat;

            out_valid <= v2;
            if (s2_nan) begin
                fixed <= 32'd0;
                flags <= 2'b10;
            end else if (s2_sat) begin
                fixed <= s2_sign ? NEG_ONE : POS_ONE;
                flags <= 2'b01;
            end else begin
                // negating a zero magnitude yields zero, so no -0 escapes
                fixed <= s2_sign ? negated : s2_mag;
                flags <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_angle_float_to_fixed.sv
// Testbench for angle_float_to_fixed: queue scoreboard with a real-valued
// reference model, random and directed stimulus, stall and reset checks.
module tb_angle_float_to_fixed;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        in_valid;
    logic [31:0] angle;
    logic        out_valid;
    logic [31:0] fixed;
    logic [1:0]  flags;

    angle_float_to_fixed dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .in_valid  (in_valid),
        .angle     (angle),
        .out_valid (out_valid),
        .fixed     (fixed),
        .flags     (flags)
    );

    typedef struct {
        logic [31:0] ang;
        logic [31:0] fx;
        logic [1:0]  fl;
        int          due;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passes = 0;
    int ecnt = 0;
    logic        exp_valid_last = 1'b0;
    logic [31:0] prev_fixed = 32'd0;
    logic [1:0]  prev_flags = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %08h expected %08h at %0t",
                      name, act, req, $time);
    endtask

    // Reference: decode the float to a real value and scale by 2^30.
    function automatic void model(input logic [31:0] a,
                                  output logic [31:0] fx,
                                  output logic [1:0] fl);
        int  e;
        real r;
        int  v;
        e = int'(a[30:23]);
        fx = 32'd0;
        fl = 2'b00;
        if (e == 255 && a[22:0] != 23'd0) begin
            fl = 2'b10;
        end else begin
            if (e == 255) r = 4.0;
            else if (e == 0) r = real'(a[22:0]) * (2.0 ** (-149));
            else r = (1.0 + real'(a[22:0]) / 8388608.0) * (2.0 ** (e - 127));
            if (r > 1.0) begin
                fl = 2'b01;
                fx = a[31] ? 32'hC000_0000 : 32'h4000_0000;
            end else begin
                v = $rtoi(r * 1073741824.0);
                fx = a[31] ? 32'(-v) : 32'(v);
            end
        end
    endfunction

    task automatic step(input bit en, input bit vld, input logic [31:0] a);
        exp_t t;
        @(negedge clk);
        reset = 1'b0;
        clk_en = en;
        in_valid = vld;
        angle = a;
        if (en && vld) begin
            model(a, t.fx, t.fl);
            t.ang = a;
            t.due = ecnt + 3;
            q.push_back(t);
        end
    endtask

    // Monitor: decides after each edge what the outputs must show.
    always @(posedge clk) begin
        logic en_s;
        logic rst_s;
        exp_t t;
        en_s = clk_en;
        rst_s = reset;
        #1;
        if (rst_s) begin
            q.delete();
            exp_valid_last = 1'b0;
            check(out_valid == 1'b0, "reset_valid", 32'(out_valid), 32'd0);
            check(fixed == 32'd0, "reset_fixed", fixed, 32'd0);
            check(flags == 2'b00, "reset_flags", 32'(flags), 32'd0);
        end else if (en_s) begin
            ecnt++;
            if (q.size() > 0 && q[0].due == ecnt) begin
                t = q.pop_front();
                exp_valid_last = 1'b1;
                check(out_valid == 1'b1, "out_valid_missing",
                      32'(out_valid), 32'd1);
                check(fixed == t.fx, $sformatf("fixed[%08h]", t.ang),
                      fixed, t.fx);
                check(flags == t.fl, $sformatf("flags[%08h]", t.ang),
                      32'(flags), 32'(t.fl));
            end else begin
                exp_valid_last = 1'b0;
                check(out_valid == 1'b0, "out_valid_spurious",
                      32'(out_valid), 32'd0);
            end
        end else begin
            check(out_valid == exp_valid_last, "stall_valid",
                  32'(out_valid), 32'(exp_valid_last));
            check(fixed == prev_fixed, "stall_fixed", fixed, prev_fixed);
            check(flags == prev_flags, "stall_flags",
                  32'(flags), 32'(prev_flags));
        end
        prev_fixed = fixed;
        prev_flags = flags;
    end

    function automatic logic [31:0] rand_angle();
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(0, 3))
            0: a[30:23] = 8'($urandom_range(94, 130));
            1: a[30:23] = 8'($urandom_range(118, 128));
            2: a[30:23] = ($urandom_range(0, 1) != 0) ? 8'd255 : 8'd0;
            default: ;
        endcase
        return a;
    endfunction

    logic [31:0] directed [19] = '{
        32'h3f800000, 32'hbf800000, 32'h3f000000, 32'hbf000000,
        32'h3f1b74ee, 32'h33800000, 32'h33000000, 32'h00000000,
        32'h80000000, 32'h00000001, 32'h437f0000, 32'hc3400000,
        32'h3f800001, 32'h7f800000, 32'h7fc00000, 32'hff800000,
        32'hb3800000, 32'h3c000000, 32'hbf7fffff
    };

    initial begin
        reset = 1'b1;
        clk_en = 1'b1;
        in_valid = 1'b0;
        angle = 32'd0;
        repeat (3) @(negedge clk);

        foreach (directed[i]) step(1'b1, 1'b1, directed[i]);

        repeat (400) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 rand_angle());
        end

        // streaming with a four-cycle stall after the third sample
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, rand_angle());
            if (i == 2) begin
                repeat (4) step(1'b0, 1'($urandom), $urandom);
            end
        end

        // valid gaps 1,0,1,1,0
        step(1'b1, 1'b1, 32'h3f000000);
        step(1'b1, 1'b0, 32'h3f800000);
        step(1'b1, 1'b1, 32'hbf000000);
        step(1'b1, 1'b1, 32'h3f1b74ee);
        step(1'b1, 1'b0, 32'hbf800000);

        // reset with three samples in flight and clk_en low
        step(1'b1, 1'b1, 32'h3f800000);
        step(1'b1, 1'b1, 32'hbf800000);
        step(1'b1, 1'b1, 32'h3f1b74ee);
        @(negedge clk);
        reset = 1'b1;
        clk_en = 1'b0;
        in_valid = 1'b0;
        step(1'b1, 1'b1, 32'h3f000000);

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            step(1'b1, 1'b0, 32'd0);
        end
        step(1'b1, 1'b0, 32'd0);
        check(q.size() == 0, "drain_timeout", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
